etapa_busqueda: RTL and testbench
=================================

Name: etapa_busqueda

Overview:
Instruction fetch stage, directly upstream of the control unit/decoder. Holds the PC and issues one word fetch at a time to instruction memory over a req/ready + valid handshake. Registers the returned instruction, with its PC and opcode field, toward decode, using a valid/ready handshake. Redirects on a taken branch from EX and discards any wrong-path fetches.

Parameters:
ANCHO_DIR, 32, PC/address width
ANCHO_INST, 32, instruction width
PC_RESET, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
salto_tomado  in  1  taken branch/jump from EX; redirect request
pc_destino  in  ANCHO_DIR  redirect target
imem_req  out  1  fetch request valid
imem_dir  out  ANCHO_DIR  fetch address, word aligned
imem_listo  in  1  memory accepts request (handshake when imem_req && imem_listo)
imem_valido  in  1  read data valid, exactly one per accepted request
imem_dato  in  ANCHO_INST  read data
inst_valida  out  1  instruction valid to decode
inst  out  ANCHO_INST  instruction word
inst_pc  out  ANCHO_DIR  PC of inst
opcode  out  7  inst[6:0], feeds control unit
dec_listo  in  1  decode accepts (transfer when inst_valida && dec_listo)

Behaviour:
- Reset (async): state REPOSO; pc=PC_RESET; imem_req=0; imem_dir=PC_RESET; inst_valida=0; inst=0; inst_pc=PC_RESET; opcode=0; descartar=0.
- Exactly one outstanding memory request at any time. All outputs are registered.
- FSM:
  - REPOSO: advances unconditionally to PEDIR on the next cycle.
  - PEDIR: imem_req=1, imem_dir=pc. On handshake, go to ESPERAR. imem_dir may change only while the request is not yet accepted.
  - ESPERAR: on imem_valido:
    - if descartar: clear descartar, go to PEDIR.
    - else: capture inst=imem_dato, inst_pc=pc, inst_valida=1 next cycle; set pc=pc+4; go to LLENO.
  - LLENO: inst_valida is held, and inst/inst_pc stay stable, until dec_listo. On transfer, deassert inst_valida next cycle and go to PEDIR.
- Latency: imem_valido at cycle N gives inst_valida=1 at N+1. Minimum fetch period is 3 cycles with zero-wait memory.
- PC arithmetic: pc+4 modulo 2^ANCHO_DIR, so 0xFFFF_FFFC wraps to 0x0000_0000. pc_destino[1:0] is forced to 0.
- Redirect (salto_tomado=1) has the highest priority in every state; pc<=pc_destino in all cases.
  - PEDIR, not accepted this cycle: next-cycle imem_dir=pc_destino; stay in PEDIR.
  - PEDIR, accepted this cycle: set descartar; go to ESPERAR.
  - ESPERAR without imem_valido: set descartar.
  - ESPERAR with imem_valido in the same cycle: drop the data; go to PEDIR.
  - LLENO: inst_valida=0 next cycle, even if dec_listo=1 in the same cycle. That transfer is void and decode flushes it too. Go to PEDIR.
  - REPOSO: the target is used for the first fetch.
- imem_valido outside ESPERAR is ignored.
- Back-to-back redirects: the last target wins. descartar stays set until the one stale response has arrived.
- Reset mid-operation: everything returns to reset values immediately. Instruction memory shares rst, so no stale response survives reset.

Decomposition:
- Shared package (paquete_riscv):
  - opcode constants: OP_TIPO_R=7'b0110011, OP_LW=7'b0000011, OP_SW=7'b0100011, OP_BRANCH=7'b1100011
  - NOP constant 32'h0000_0013
  - FSM state encoding (REPOSO, PEDIR, ESPERAR, LLENO)
- One sub-module: registro_pc. It holds the PC register, the +4 incrementer with wrap, redirect muxing and alignment masking.

Test Plan:
- Reset release, zero-wait memory returning 0x00000033, dec_listo=1 → imem_dir 0x0, 0x4, 0x8, each three cycles apart; first inst_valida with inst=0x00000033, inst_pc=0x0, opcode=0x33.
- dec_listo=0 for 5 cycles while LLENO → inst/inst_pc stable, imem_req=0 throughout, no new fetch until transfer.
- salto_tomado with pc_destino=0x100 while ESPERAR, response arriving 2 cycles later → that response is never presented; next imem_dir=0x100.
- salto_tomado and dec_listo in the same LLENO cycle, pc_destino=0x203 → inst_valida=0 next cycle; next fetch address 0x200.
- PC_RESET=0xFFFF_FFFC → fetch 0xFFFF_FFFC, then 0x0000_0000.
- Assert rst while ESPERAR → all outputs at reset values in the same cycle; fetch restarts at PC_RESET after release.

Source files
------------

// File: rtl/paquete_riscv.sv
// rtl/paquete_riscv.sv - shared opcodes, NOP word and fetch FSM state encoding
package paquete_riscv;

  localparam logic [6:0] OP_TIPO_R = 7'b0110011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    PEDIR   = 2'd1,
    ESPERAR = 2'd2,
    LLENO   = 2'd3
  } estado_t;

endpackage

// File: rtl/etapa_busqueda_registro_pc.sv
// rtl/etapa_busqueda_registro_pc.sv - PC register with +4 increment and word-aligned redirect
module registro_pc #(
  parameter int                   ANCHO_DIR = 32,
  parameter logic [ANCHO_DIR-1:0] PC_RESET  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_salto,
  input  logic [ANCHO_DIR-1:0] i_destino,
  input  logic                 i_incrementar,
  output logic [ANCHO_DIR-1:0] o_pc,
  output logic [ANCHO_DIR-1:0] o_pc_sig
);

  logic [ANCHO_DIR-1:0] r_pc;
  logic [ANCHO_DIR-1:0] w_pc_sig;

  // Redirect beats increment; the sum wraps naturally at 2^ANCHO_DIR.
  always_comb begin
    w_pc_sig = r_pc;
    if (i_salto) begin
      w_pc_sig = {i_destino[ANCHO_DIR-1:2], 2'b00};
    end else if (i_incrementar) begin
      w_pc_sig = r_pc + ANCHO_DIR'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= PC_RESET;
    end else begin
      r_pc <= w_pc_sig;
    end
  end

  assign o_pc     = r_pc;
  assign o_pc_sig = w_pc_sig;

endmodule

// File: rtl/etapa_busqueda.sv
// rtl/etapa_busqueda.sv - instruction fetch stage: one outstanding imem request, registered output to decode
module etapa_busqueda
  import paquete_riscv::*;
#(
  parameter int                   ANCHO_DIR  = 32,
  parameter int                   ANCHO_INST = 32,
  parameter logic [ANCHO_DIR-1:0] PC_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  salto_tomado,
  input  logic [ANCHO_DIR-1:0]  pc_destino,
  output logic                  imem_req,
  output logic [ANCHO_DIR-1:0]  imem_dir,
  input  logic                  imem_listo,
  input  logic                  imem_valido,
  input  logic [ANCHO_INST-1:0] imem_dato,
  output logic                  inst_valida,
  output logic [ANCHO_INST-1:0] inst,
  output logic [ANCHO_DIR-1:0]  inst_pc,
  output logic [6:0]            opcode,
  input  logic                  dec_listo
);

  estado_t               r_estado;
  logic                  r_req;
  logic [ANCHO_DIR-1:0]  r_dir;
  logic                  r_valida;
  logic [ANCHO_INST-1:0] r_inst;
  logic [ANCHO_DIR-1:0]  r_inst_pc;
  logic [6:0]            r_opcode;
  logic                  r_descartar;

  logic [ANCHO_DIR-1:0]  w_pc;
  logic [ANCHO_DIR-1:0]  w_pc_sig;
  logic                  w_acepta;
  logic                  w_capturar;

  assign w_acepta   = r_req && imem_listo;
  assign w_capturar = (r_estado == ESPERAR) && imem_valido && !r_descartar && !salto_tomado;

  registro_pc #(
    .ANCHO_DIR (ANCHO_DIR),
    .PC_RESET  (PC_RESET)
  ) u_registro_pc (
    .clk           (clk),
    .rst           (rst),
    .i_salto       (salto_tomado),
    .i_destino     (pc_destino),
    .i_incrementar (w_capturar),
    .o_pc          (w_pc),
    .o_pc_sig      (w_pc_sig)
  );

  // Whenever a request is (re)issued its address is the PC as it will be next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado    <= REPOSO;
      r_req       <= 1'b0;
      r_dir       <= PC_RESET;
      r_valida    <= 1'b0;
      r_inst      <= '0;
      r_inst_pc   <= PC_RESET;
      r_opcode    <= '0;
      r_descartar <= 1'b0;
    end else begin
      case (r_estado)
        REPOSO: begin
          r_estado <= PEDIR;
          r_req    <= 1'b1;
          r_dir    <= w_pc_sig;
        end
        PEDIR: begin
          if (w_acepta) begin
            r_estado    <= ESPERAR;
            r_req       <= 1'b0;
            r_descartar <= salto_tomado;
          end else begin
            r_dir <= w_pc_sig;
          end
        end
        ESPERAR: begin
          if (imem_valido) begin
            r_descartar <= 1'b0;
            if (w_capturar) begin
              r_estado  <= LLENO;
              r_valida  <= 1'b1;
              r_inst    <= imem_dato;
              r_inst_pc <= w_pc;
              r_opcode  <= imem_dato[6:0];
            end else begin
              r_estado <= PEDIR;
              r_req    <= 1'b1;
              r_dir    <= w_pc_sig;
            end
          end else if (salto_tomado) begin
            r_descartar <= 1'b1;
          end
        end
        LLENO: begin
          // A redirect voids a transfer that coincides with it.
          if (salto_tomado || dec_listo) begin
            r_estado <= PEDIR;
            r_valida <= 1'b0;
            r_req    <= 1'b1;
            r_dir    <= w_pc_sig;
          end
        end
        default: r_estado <= REPOSO;
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_dir    = r_dir;
  assign inst_valida = r_valida;
  assign inst        = r_inst;
  assign inst_pc     = r_inst_pc;
  assign opcode      = r_opcode;

endmodule

// File: tb/tb_etapa_busqueda.sv
// tb/tb_etapa_busqueda.sv - self-checking bench for etapa_busqueda
module tb_etapa_busqueda;

  localparam logic [31:0] PC_RST   = 32'h0000_0000;
  localparam logic [31:0] PC_RST_B = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, salto_tomado, dec_listo;
  logic [31:0] pc_destino;
  logic        imem_req, imem_listo, imem_valido, inst_valida;
  logic [31:0] imem_dir, imem_dato, inst, inst_pc;
  logic [6:0]  opcode;

  logic        salto_b, dec_listo_b, imem_req_b, imem_listo_b, imem_valido_b, inst_valida_b;
  logic [31:0] destino_b, imem_dir_b, imem_dato_b, inst_b, inst_pc_b;
  logic [6:0]  opcode_b;

  etapa_busqueda #(.ANCHO_DIR(32), .ANCHO_INST(32), .PC_RESET(PC_RST)) u_dut (
    .clk(clk), .rst(rst), .salto_tomado(salto_tomado), .pc_destino(pc_destino),
    .imem_req(imem_req), .imem_dir(imem_dir), .imem_listo(imem_listo),
    .imem_valido(imem_valido), .imem_dato(imem_dato), .inst_valida(inst_valida),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode), .dec_listo(dec_listo)
  );

  etapa_busqueda #(.ANCHO_DIR(32), .ANCHO_INST(32), .PC_RESET(PC_RST_B)) u_dut_b (
    .clk(clk), .rst(rst), .salto_tomado(salto_b), .pc_destino(destino_b),
    .imem_req(imem_req_b), .imem_dir(imem_dir_b), .imem_listo(imem_listo_b),
    .imem_valido(imem_valido_b), .imem_dato(imem_dato_b), .inst_valida(inst_valida_b),
    .inst(inst_b), .inst_pc(inst_pc_b), .opcode(opcode_b), .dec_listo(dec_listo_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        mem_const;
  int          lat_min, lat_max, listo_pct;
  logic [31:0] dato_emitido [logic [31:0]];

  logic [31:0] hs_dir [$];
  int          hs_cyc [$];
  logic [31:0] hs_dir_b [$];
  int          first_v_cyc, first_vld_cyc;
  logic [31:0] fv_inst, fv_pc;
  logic [6:0]  fv_op;
  int          n_trans = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_const) return 32'h0000_0033;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (imem_req && imem_listo) begin
      hs_dir.push_back(imem_dir);
      hs_cyc.push_back(cyc);
    end
    if (imem_req_b && imem_listo_b) hs_dir_b.push_back(imem_dir_b);
    if (imem_valido && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (inst_valida && first_v_cyc < 0) begin
      first_v_cyc = cyc;
      fv_inst = inst;
      fv_pc = inst_pc;
      fv_op = opcode;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic esperar_valida(input string tag, input int max);
    int k = 0;
    while (!inst_valida && k < max) begin
      tick();
      k++;
    end
    chk(tag, 32'(inst_valida), 32'd1);
  endtask

  task automatic esperar_hs(input string tag, input int max);
    int n0 = hs_dir.size();
    int k = 0;
    while (hs_dir.size() == n0 && k < max) begin
      tick();
      k++;
    end
    chk(tag, 32'(hs_dir.size() > n0), 32'd1);
  endtask

  // Instruction memory: one response per accepted request after a random latency.
  logic        m_hs, m_vld, m_hs_b, st_prev;
  logic [31:0] m_dir, st_dir, p_dir, dato;
  int          pend, cnt;

  initial begin
    imem_listo = 1'b1; imem_valido = 1'b0; imem_dato = '0;
    imem_valido_b = 1'b0; imem_dato_b = 32'h0000_0013; imem_listo_b = 1'b1;
    pend = 0; cnt = 0; st_prev = 1'b0; st_dir = '0; p_dir = '0;
    forever begin
      @(negedge clk);
      m_hs = imem_req && imem_listo;
      m_vld = imem_valido;
      m_dir = imem_dir;
      m_hs_b = imem_req_b && imem_listo_b;
      if (st_prev && !rst) begin
        chk("req_estable", 32'(imem_req), 32'd1);
        chk("dir_estable", imem_dir, st_dir);
      end
      st_prev = imem_req && !imem_listo && !salto_tomado && !rst;
      st_dir = imem_dir;
      @(posedge clk);
      #1;
      if (rst) begin
        pend = 0; cnt = 0;
        imem_valido = 1'b0; imem_valido_b = 1'b0;
      end else begin
        if (m_vld && pend > 0) pend--;
        if (m_hs) begin
          chk("una_pendiente", 32'(pend), 32'd0);
          pend++;
          cnt = $urandom_range(lat_max, lat_min);
          p_dir = m_dir;
        end
        if (pend > 0 && cnt == 0) begin
          dato = mem_word(p_dir);
          dato_emitido[p_dir] = dato;
          imem_valido = 1'b1;
          imem_dato = dato;
        end else begin
          imem_valido = 1'b0;
          imem_dato = $urandom;
          if (pend > 0) cnt--;
        end
        imem_listo = ($urandom_range(99, 0) < listo_pct);
        imem_valido_b = m_hs_b;
      end
    end
  end

  // Decode-side reference: instructions arrive in program order from the last redirect target.
  logic [31:0] exp_pc = PC_RST;
  logic [31:0] exp_inst;
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = PC_RST;
    end else if (salto_tomado) begin
      exp_pc = pc_destino & 32'hFFFF_FFFC;
    end else if (inst_valida && dec_listo) begin
      exp_inst = dato_emitido.exists(exp_pc) ? dato_emitido[exp_pc] : 32'hDEAD_BEEF;
      chk("sb_inst_pc", inst_pc, exp_pc);
      chk("sb_inst", inst, exp_inst);
      chk("sb_opcode", 32'(opcode), 32'(exp_inst[6:0]));
      exp_pc = exp_pc + 32'd4;
      n_trans++;
    end
  end

  logic [31:0] i0, pc0;
  int          n0;

  initial begin
    rst = 1'b1; salto_tomado = 1'b0; pc_destino = '0; dec_listo = 1'b1;
    salto_b = 1'b0; destino_b = '0; dec_listo_b = 1'b1;
    mem_const = 1'b1; lat_min = 0; lat_max = 0; listo_pct = 100;
    first_v_cyc = -1; first_vld_cyc = -1;
    repeat (3) tick();

    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_dir", imem_dir, PC_RST);
    chk("rst_valida", 32'(inst_valida), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, PC_RST);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_dir_b", imem_dir_b, PC_RST_B);

    hs_dir.delete(); hs_cyc.delete(); hs_dir_b.delete();
    first_v_cyc = -1; first_vld_cyc = -1;
    rst = 1'b0;
    repeat (12) tick();
    chk("t1_nfetch", 32'(hs_dir.size() >= 3), 32'd1);
    chk("t1_dir0", hs_dir[0], 32'h0);
    chk("t1_dir1", hs_dir[1], 32'h4);
    chk("t1_dir2", hs_dir[2], 32'h8);
    chk("t1_periodo1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
    chk("t1_periodo2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
    chk("t1_inst", fv_inst, 32'h0000_0033);
    chk("t1_inst_pc", fv_pc, 32'h0);
    chk("t1_opcode", 32'(fv_op), 32'h33);
    chk("t1_latencia", 32'(first_v_cyc - first_vld_cyc), 32'd1);
    chk("t5b_dir0", hs_dir_b[0], 32'hFFFF_FFFC);
    chk("t5b_dir1", hs_dir_b[1], 32'h0000_0000);

    mem_const = 1'b0;
    dec_listo = 1'b0;
    esperar_valida("t2_espera", 20);
    i0 = inst; pc0 = inst_pc; n0 = hs_dir.size();
    repeat (5) begin
      tick();
      chk("t2_inst", inst, i0);
      chk("t2_inst_pc", inst_pc, pc0);
      chk("t2_req", 32'(imem_req), 32'd0);
      chk("t2_valida", 32'(inst_valida), 32'd1);
    end
    chk("t2_sin_fetch", 32'(hs_dir.size()), 32'(n0));
    dec_listo = 1'b1;
    tick();
    chk("t2_baja", 32'(inst_valida), 32'd0);
    chk("t2_pide", 32'(imem_req), 32'd1);

    lat_min = 2; lat_max = 2;
    esperar_hs("t3_hs", 20);
    salto_tomado = 1'b1; pc_destino = 32'h0000_0100;
    tick();
    salto_tomado = 1'b0;
    n0 = hs_dir.size();
    esperar_hs("t3_hs2", 20);
    chk("t3_dir", hs_dir[n0], 32'h0000_0100);
    lat_min = 0; lat_max = 0;
    esperar_valida("t3_espera", 20);
    chk("t3_inst_pc", inst_pc, 32'h0000_0100);
    chk("t3_inst", inst, mem_word(32'h0000_0100));

    dec_listo = 1'b0;
    esperar_valida("t4_espera", 20);
    salto_tomado = 1'b1; pc_destino = 32'h0000_0203; dec_listo = 1'b1;
    tick();
    salto_tomado = 1'b0;
    chk("t4_valida", 32'(inst_valida), 32'd0);
    n0 = hs_dir.size();
    esperar_hs("t4_hs", 20);
    chk("t4_dir", hs_dir[n0], 32'h0000_0200);
    esperar_valida("t4_espera2", 20);
    chk("t4_inst_pc", inst_pc, 32'h0000_0200);

    esperar_hs("t5_hs", 20);
    rst = 1'b1;
    #1;
    chk("t5_req", 32'(imem_req), 32'd0);
    chk("t5_dir", imem_dir, PC_RST);
    chk("t5_valida", 32'(inst_valida), 32'd0);
    chk("t5_inst", inst, 32'd0);
    chk("t5_inst_pc", inst_pc, PC_RST);
    chk("t5_opcode", 32'(opcode), 32'd0);
    tick(); tick();
    rst = 1'b0;
    hs_dir.delete(); hs_cyc.delete();
    esperar_hs("t5_hs2", 20);
    chk("t5_dir_reinicio", hs_dir[0], PC_RST);

    lat_min = 0; lat_max = 3; listo_pct = 70;
    n0 = n_trans;
    for (int i = 0; i < 1500; i++) begin
      dec_listo = ($urandom_range(3, 0) != 0);
      salto_tomado = ($urandom_range(19, 0) == 0);
      pc_destino = $urandom;
      tick();
    end
    salto_tomado = 1'b0; dec_listo = 1'b1;
    tick();
    chk("t6_transferencias", 32'(n_trans - n0 > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
